// File: rtl/gpio_pixel_receiver.sv
// Collects R, G and B channel words from GPIO strobes into 4-pixel RGB888 groups.
// Completed groups are queued in a small FIFO for the downstream pixel consumer.
module gpio_pixel_receiver #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] GPIO,
   input  logic        GPIOEnR,
   input  logic        GPIOEnG,
   input  logic        GPIOEnB,
   input  logic        GPIOEn,
   input  logic        err_clr,
   input  logic        pix_ready,
   output logic        pix_valid,
   output logic [95:0] pix_data,
   output logic [15:0] frame_len,
   output logic        frame_done,
   output logic        busy,
   output logic        err_seq,
   output logic        err_ovf
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, WAIT_R, WAIT_G, WAIT_B, DONE} state_t;

   state_t      state_reg, state_next;
   logic [31:0] r_word_reg, g_word_reg;
   logic [15:0] grp_cnt_reg, frame_len_reg;
   logic        err_seq_reg, err_ovf_reg;
   logic [95:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0] count_reg;

   logic        any_ch, multi_strobe, hdr_ok;
   logic        seq_err, hdr_take, latch_r, latch_g, push;
   logic        fifo_full, pop, wr_en, ovf_set;
   logic [95:0] group_word;

   assign any_ch       = GPIOEnR | GPIOEnG | GPIOEnB;
   assign multi_strobe = $countones({GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn}) > 1;
   assign hdr_ok       = GPIOEn && (GPIO[31:16] == 16'hA5A5);

   // Blue comes straight from GPIO so the group is pushed in the strobe cycle.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_pix
         assign group_word[24*gi +: 24] = {r_word_reg[8*gi +: 8], g_word_reg[8*gi +: 8], GPIO[8*gi +: 8]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      seq_err    = 1'b0;
      hdr_take   = 1'b0;
      latch_r    = 1'b0;
      latch_g    = 1'b0;
      push       = 1'b0;
      if (multi_strobe) begin
         seq_err    = 1'b1;
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_ch)      seq_err  = 1'b1;
               else if (hdr_ok) hdr_take = 1'b1;
            end
            WAIT_R: begin
               if (hdr_ok) begin
                  seq_err = 1'b1; hdr_take = 1'b1;
               end else if (GPIOEnR) begin
                  latch_r = 1'b1; state_next = WAIT_G;
               end else if (any_ch) begin
                  seq_err = 1'b1; state_next = IDLE;
               end
            end
            WAIT_G: begin
               if (hdr_ok) begin
                  seq_err = 1'b1; hdr_take = 1'b1;
               end else if (GPIOEnG) begin
                  latch_g = 1'b1; state_next = WAIT_B;
               end else if (any_ch) begin
                  seq_err = 1'b1; state_next = IDLE;
               end
            end
            WAIT_B: begin
               if (hdr_ok) begin
                  seq_err = 1'b1; hdr_take = 1'b1;
               end else if (GPIOEnB) begin
                  push       = 1'b1;
                  state_next = (grp_cnt_reg + 16'd1 == frame_len_reg) ? DONE : WAIT_R;
               end else if (any_ch) begin
                  seq_err = 1'b1; state_next = IDLE;
               end
            end
            DONE: begin
               state_next = IDLE;
               if (any_ch) seq_err = 1'b1;
            end
            default: state_next = IDLE;
         endcase
         if (hdr_take) state_next = (GPIO[15:0] == 16'd0) ? DONE : WAIT_R;
      end
   end

   always_comb begin
      frame_done = (state_reg == DONE);
      busy       = (state_reg != IDLE);
   end

   assign fifo_full = (count_reg == DEPTH_C);
   assign pix_valid = (count_reg != '0);
   assign pop       = pix_valid && pix_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign wr_en     = push && (!fifo_full || pop);
   assign ovf_set   = push && fifo_full && !pop;
   assign pix_data  = pix_valid ? mem[rd_ptr_reg] : '0;

   assign frame_len = frame_len_reg;
   assign err_seq   = err_seq_reg;
   assign err_ovf   = err_ovf_reg;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= group_word;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_word_reg    <= '0;
         g_word_reg    <= '0;
         grp_cnt_reg   <= '0;
         frame_len_reg <= '0;
         err_seq_reg   <= 1'b0;
         err_ovf_reg   <= 1'b0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
      end else begin
         if (latch_r) r_word_reg <= GPIO;
         if (latch_g) g_word_reg <= GPIO;
         if (hdr_take) begin
            frame_len_reg <= GPIO[15:0];
            grp_cnt_reg   <= '0;
         end else if (push) begin
            grp_cnt_reg <= grp_cnt_reg + 16'd1;
         end
         if (seq_err)      err_seq_reg <= 1'b1;
         else if (err_clr) err_seq_reg <= 1'b0;
         if (ovf_set)      err_ovf_reg <= 1'b1;
         else if (err_clr) err_ovf_reg <= 1'b0;
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
      end
   end

endmodule

// File: tb/tb_gpio_pixel_receiver.sv
// Directed bench for gpio_pixel_receiver: framing, FIFO overflow/simultaneous pop,
// sequence errors and mid-frame reset.
module tb_gpio_pixel_receiver;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] GPIO;
   logic        GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn;
   logic        err_clr, pix_ready;
   logic        pix_valid;
   logic [95:0] pix_data;
   logic [15:0] frame_len;
   logic        frame_done, busy, err_seq, err_ovf;

   int tests = 0;
   int fails = 0;

   gpio_pixel_receiver #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .GPIO(GPIO),
      .GPIOEnR(GPIOEnR), .GPIOEnG(GPIOEnG), .GPIOEnB(GPIOEnB), .GPIOEn(GPIOEn),
      .err_clr(err_clr), .pix_ready(pix_ready),
      .pix_valid(pix_valid), .pix_data(pix_data), .frame_len(frame_len),
      .frame_done(frame_done), .busy(busy), .err_seq(err_seq), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic r, input logic g, input logic b, input logic h, input logic [31:0] d);
      @(negedge clk);
      GPIO = d; GPIOEnR = r; GPIOEnG = g; GPIOEnB = b; GPIOEn = h;
      @(posedge clk); #1;
      GPIOEnR = 1'b0; GPIOEnG = 1'b0; GPIOEnB = 1'b0; GPIOEn = 1'b0;
   endtask

   task automatic group(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
      strobe(1'b1, 1'b0, 1'b0, 1'b0, r);
      strobe(1'b0, 1'b1, 1'b0, 1'b0, g);
      strobe(1'b0, 1'b0, 1'b1, 1'b0, b);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_errors();
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0; GPIO = '0; GPIOEnR = 0; GPIOEnG = 0; GPIOEnB = 0; GPIOEn = 0;
      err_clr = 0; pix_ready = 1'b1;
      repeat (3) tick();
      check("reset_valid", 96'(pix_valid), 96'd0);
      check("reset_data", pix_data, 96'd0);
      check("reset_busy", 96'(busy), 96'd0);
      check("reset_flen", 96'(frame_len), 96'd0);
      @(negedge clk); rst = 1'b1;
      tick();

      // two-group frame with consumer always ready
      strobe(0, 0, 0, 1, 32'hA5A5_0002);
      check("hdr_busy", 96'(busy), 96'd1);
      check("hdr_flen", 96'(frame_len), 96'd2);
      group(32'h0403_0201, 32'h1413_1211, 32'h2423_2221);
      check("g1_valid", 96'(pix_valid), 96'd1);
      check("g1_data", pix_data, 96'h041424_031323_021222_011121);
      check("g1_nodone", 96'(frame_done), 96'd0);
      group(32'h0403_0201, 32'h1413_1211, 32'h2423_2221);
      check("g2_data", pix_data, 96'h041424_031323_021222_011121);
      check("g2_done", 96'(frame_done), 96'd1);
      tick();
      check("g2_done_off", 96'(frame_done), 96'd0);
      check("g2_idle", 96'(busy), 96'd0);
      check("g2_drained", 96'(pix_valid), 96'd0);

      // zero-length frame
      strobe(0, 0, 0, 1, 32'hA5A5_0000);
      check("zl_done", 96'(frame_done), 96'd1);
      check("zl_busy", 96'(busy), 96'd1);
      check("zl_novalid", 96'(pix_valid), 96'd0);
      tick();
      check("zl_done_off", 96'(frame_done), 96'd0);
      check("zl_busy_off", 96'(busy), 96'd0);

      // bad signature is ignored silently
      strobe(0, 0, 0, 1, 32'h1234_0002);
      check("badsig_busy", 96'(busy), 96'd0);
      check("badsig_err", 96'(err_seq), 96'd0);

      // channel out of order
      strobe(0, 0, 0, 1, 32'hA5A5_0002);
      strobe(0, 1, 0, 0, 32'h0000_0055);
      check("ooo_err", 96'(err_seq), 96'd1);
      check("ooo_idle", 96'(busy), 96'd0);
      check("ooo_nopush", 96'(pix_valid), 96'd0);
      clear_errors();
      check("ooo_clr", 96'(err_seq), 96'd0);

      // two strobes in one cycle
      strobe(0, 0, 0, 1, 32'hA5A5_0002);
      strobe(1, 1, 0, 0, 32'h0000_0055);
      check("multi_err", 96'(err_seq), 96'd1);
      check("multi_idle", 96'(busy), 96'd0);
      clear_errors();

      // header arriving mid-group aborts and restarts
      strobe(0, 0, 0, 1, 32'hA5A5_0002);
      strobe(1, 0, 0, 0, 32'h0000_0011);
      strobe(0, 0, 0, 1, 32'hA5A5_0007);
      check("abort_err", 96'(err_seq), 96'd1);
      check("abort_busy", 96'(busy), 96'd1);
      check("abort_flen", 96'(frame_len), 96'd7);
      strobe(0, 1, 0, 0, 32'h0);
      check("abort_seq_idle", 96'(busy), 96'd0);
      clear_errors();

      // overflow: six groups into a depth-4 FIFO with no consumer
      pix_ready = 1'b0;
      strobe(0, 0, 0, 1, 32'hA5A5_0006);
      for (int k = 1; k <= 6; k++) begin
         group(32'(k), 32'h0, 32'h0);
         if (k == 4) check("ovf_before", 96'(err_ovf), 96'd0);
      end
      check("ovf_set", 96'(err_ovf), 96'd1);
      check("ovf_done", 96'(frame_done), 96'd1);
      clear_errors();
      check("ovf_clr", 96'(err_ovf), 96'd0);
      pix_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovf_order%0d", k), pix_data, 96'(k) << 16);
         tick();
      end
      check("ovf_empty", 96'(pix_valid), 96'd0);

      // reset in the middle of a frame
      pix_ready = 1'b0;
      strobe(0, 0, 0, 1, 32'hA5A5_0003);
      group(32'h0000_0009, 32'h0, 32'h0);
      strobe(1, 0, 0, 0, 32'h0000_0008);
      @(negedge clk);
      rst = 1'b0; GPIOEnG = 1'b1; GPIO = 32'h0000_0007;
      @(posedge clk); #1;
      GPIOEnG = 1'b0;
      check("mrst_valid", 96'(pix_valid), 96'd0);
      check("mrst_data", pix_data, 96'd0);
      check("mrst_flen", 96'(frame_len), 96'd0);
      check("mrst_busy", 96'(busy), 96'd0);
      check("mrst_err", 96'({err_seq, err_ovf, frame_done}), 96'd0);
      @(negedge clk); rst = 1'b1;
      tick();
      check("mrst_after", 96'({pix_valid, busy, err_seq}), 96'd0);

      // push and pop together while full
      strobe(0, 0, 0, 1, 32'hA5A5_0005);
      for (int k = 1; k <= 4; k++) group(32'(k), 32'h0, 32'h0);
      strobe(1, 0, 0, 0, 32'd5);
      strobe(0, 1, 0, 0, 32'h0);
      pix_ready = 1'b1;
      strobe(0, 0, 1, 0, 32'h0);
      pix_ready = 1'b0;
      check("full_pp_noovf", 96'(err_ovf), 96'd0);
      check("full_pp_done", 96'(frame_done), 96'd1);
      check("full_pp_head", pix_data, 96'(2) << 16);
      pix_ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         check($sformatf("full_pp_order%0d", k), pix_data, 96'(k) << 16);
         tick();
      end
      check("full_pp_empty", 96'(pix_valid), 96'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gpio_pixel_receiver.md
GPIO_PIXEL_RECEIVER -- requirements
Module: gpio_pixel_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: pixel-group FIFO entries, power of two, >=2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port GPIO  input  32  data word from the memory-stage GPIO output.
REQ-005 SHALL have ports GPIOEnR, GPIOEnG, GPIOEnB  input  1 each  one-cycle strobes qualifying GPIO as red, green or blue channel word.
REQ-006 SHALL have port GPIOEn  input  1  one-cycle strobe qualifying GPIO as a frame header word.
REQ-007 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-008 SHALL have port pix_ready  input  1  downstream accepts a pixel group.
REQ-009 SHALL have port pix_valid  output  1  pix_data holds a valid group.
REQ-010 SHALL have port pix_data  output  96  four RGB888 pixels; pixel i at [24i+23:24i] = {R,G,B}.
REQ-011 SHALL have ports frame_len  output  16 (groups in current frame), frame_done  output  1 (one-cycle pulse), busy  output  1 (state != IDLE).
REQ-012 SHALL have ports err_seq, err_ovf  output  1 each  sticky sequence and overflow errors.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_R, WAIT_G, WAIT_B, DONE.
REQ-014 SHALL accept a header only when GPIOEn=1 and GPIO[31:16]=16'hA5A5; frame_len <= GPIO[15:0]; group counter <= 0; next state WAIT_R, or DONE if GPIO[15:0]=0.
REQ-015 SHALL ignore GPIOEn with a bad signature (no state change, no error).
REQ-016 SHALL, in WAIT_R on GPIOEnR, latch GPIO into the R register and go to WAIT_G; likewise WAIT_G on GPIOEnG -> G register -> WAIT_B.
REQ-017 SHALL, in WAIT_B on GPIOEnB, push the assembled group (byte i = channel word bits [8i+7:8i]) into the FIFO the same cycle, increment the group counter, and go to DONE if counter+1 = frame_len, else WAIT_R.
REQ-018 SHALL assert frame_done for exactly the single cycle spent in DONE, then go to IDLE.
REQ-019 SHALL treat as a sequence error: a channel strobe not matching the current WAIT state, any channel strobe in IDLE or DONE, or more than one of GPIOEnR/G/B/GPIOEn in the same cycle. On a sequence error it SHALL set err_seq, discard the partial group, and go to IDLE.
REQ-020 SHALL treat a valid header in WAIT_R/G/B as an abort: set err_seq, discard the partial group, and start the new frame per REQ-014.
REQ-021 SHALL present the FIFO head on pix_data with pix_valid=1 whenever the FIFO is non-empty; a pop occurs when pix_valid && pix_ready.
REQ-022 SHALL give latency GPIOEnB edge t -> pix_valid=1 at t+1 when the FIFO is empty (no bypass path).
REQ-023 SHALL, on a push while the FIFO is full and no pop occurs that cycle, drop the group, set err_ovf, and still count the group toward frame_len; a push with a simultaneous pop when full SHALL succeed.
REQ-024 SHALL wrap FIFO pointers modulo FIFO_DEPTH and SHALL keep an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-025 SHALL clear err_seq/err_ovf on err_clr unless a new error is detected in the same cycle (set wins).

Reset
REQ-026 SHALL, when rst=0 at a clock edge, force: state IDLE, FIFO empty, pix_valid=0, pix_data=0, frame_len=0, counter=0, frame_done=0, busy=0, err_seq=0, err_ovf=0; this applies mid-frame as well and SHALL discard all data.
REQ-027 SHALL ignore all strobes on cycles where rst=0.

Verification
REQ-028 Header 0xA5A50002, then R=0x04030201, G=0x14131211, B=0x24232221 twice, pix_ready=1 -> two groups, pixel0=0x011121, pixel3=0x041424; frame_done pulse one cycle after second B.
REQ-029 Header 0xA5A50000 -> DONE next cycle, frame_done one cycle, no pix_valid, busy high one cycle.
REQ-030 Header N=6, pix_ready=0, six full groups -> first four stored, groups 5-6 dropped, err_ovf=1, frame_done still asserted; err_clr -> err_ovf=0.
REQ-031 Header, then GPIOEnG before GPIOEnR -> err_seq=1, state IDLE, no push; GPIOEnR+GPIOEnG in the same cycle -> err_seq=1.
REQ-032 Header N=3, one group, rst=0 while in WAIT_G -> all outputs at reset values the next cycle, FIFO empty.
REQ-033 FIFO full, pix_ready=1 and GPIOEnB in the same cycle -> no err_ovf, occupancy unchanged, order preserved.
